// File: rtl/rsa_host_ctrl_if.sv
// Host-side stream and RSA register port signals for rsa_host_ctrl.
interface rsa_host_ctrl_if;
    // Upstream byte stream (key words, then ciphertext)
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    // Downstream result byte stream
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    // Host control and status
    logic       rekey;
    logic       busy;
    logic [7:0] blk_cnt;
    // Byte-wide RSA register port
    logic       rsa_we;
    logic       rsa_oe;
    logic       rsa_start;
    logic [1:0] rsa_reg_sel;
    logic [4:0] rsa_addr;
    logic [7:0] rsa_data_i;
    logic [7:0] rsa_data_o;
    logic       rsa_ready;

    // Controller side
    modport master (
        input  in_valid, in_data, out_ready, rekey, rsa_data_o, rsa_ready,
        output in_ready, out_valid, out_data, busy, blk_cnt,
               rsa_we, rsa_oe, rsa_start, rsa_reg_sel, rsa_addr, rsa_data_i
    );

    // Environment side (stream source/sink and RSA core)
    modport slave (
        output in_valid, in_data, out_ready, rekey, rsa_data_o, rsa_ready,
        input  in_ready, out_valid, out_data, busy, blk_cnt,
               rsa_we, rsa_oe, rsa_start, rsa_reg_sel, rsa_addr, rsa_data_i
    );
endinterface

// File: rtl/rsa_host_ctrl.sv
// Host master for the byte-wide RSA register port: loads the two key words
// and a ciphertext block, starts the core, waits for its ready edge and
// streams the 32 result bytes out one at a time.
module rsa_host_ctrl (
    input  logic           clk,
    input  logic           reset,
    rsa_host_ctrl_if.master bus
);
    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DAT_W = 8;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(31);

    localparam logic [1:0] SEL_KEY_A  = 2'd3;
    localparam logic [1:0] SEL_KEY_B  = 2'd2;
    localparam logic [1:0] SEL_CIPHER = 2'd1;
    localparam logic [1:0] SEL_RESULT = 2'd0;

    typedef enum logic [3:0] {
        LOAD_A, LOAD_B, LOAD_C, GAP, START, WAIT, RD_REQ, RD_CAP, OUT_HOLD
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               rdy_q;
    logic [CNT_W-1:0]   blk_cnt_q;

    logic               rsa_we_q;
    logic               rsa_oe_q;
    logic               rsa_start_q;
    logic [1:0]         rsa_reg_sel_q;
    logic [IDX_W-1:0]   rsa_addr_q;
    logic [DAT_W-1:0]   rsa_data_i_q;
    logic               out_valid_q;
    logic [DAT_W-1:0]   out_data_q;

    logic               is_load_c;
    logic               in_ready_c;
    logic               accept_c;
    logic               rekey_hit_c;
    logic               rdy_rise_c;
    logic               idle_c;
    logic [1:0]         load_sel_c;
    state_t             load_next_c;

    // Handshake qualifiers; rekey masks in_ready so it always wins over a byte
    always_comb begin
        is_load_c   = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_C);
        idle_c      = (state == LOAD_C) && (idx == '0);
        in_ready_c  = is_load_c && !bus.rekey;
        accept_c    = bus.in_valid && in_ready_c;
        rekey_hit_c = idle_c && bus.rekey;
        rdy_rise_c  = bus.rsa_ready && !rdy_q;
    end

    // Register select and successor for each load phase
    always_comb begin
        load_sel_c  = SEL_CIPHER;
        load_next_c = GAP;
        case (state)
            LOAD_A: begin
                load_sel_c  = SEL_KEY_A;
                load_next_c = LOAD_B;
            end
            LOAD_B: begin
                load_sel_c  = SEL_KEY_B;
                load_next_c = LOAD_C;
            end
            default: begin
                load_sel_c  = SEL_CIPHER;
                load_next_c = GAP;
            end
        endcase
    end

    // Main controller: state, byte index, ready edge history and registered port outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= LOAD_A;
            idx           <= '0;
            rdy_q         <= 1'b0;
            blk_cnt_q     <= '0;
            rsa_we_q      <= 1'b0;
            rsa_oe_q      <= 1'b0;
            rsa_start_q   <= 1'b0;
            rsa_reg_sel_q <= '0;
            rsa_addr_q    <= '0;
            rsa_data_i_q  <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            rdy_q       <= bus.rsa_ready;
            rsa_we_q    <= 1'b0;
            rsa_start_q <= 1'b0;
            case (state)
                LOAD_A, LOAD_B, LOAD_C: begin
                    if (rekey_hit_c) begin
                        state <= LOAD_A;
                        idx   <= '0;
                    end else if (accept_c) begin
                        rsa_we_q      <= 1'b1;
                        rsa_reg_sel_q <= load_sel_c;
                        rsa_addr_q    <= idx;
                        rsa_data_i_q  <= bus.in_data;
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= load_next_c;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                // The final ciphertext write occupies this cycle; START follows with a quiet bus
                GAP: begin
                    state <= START;
                end
                START: begin
                    rsa_start_q   <= 1'b1;
                    rsa_reg_sel_q <= SEL_RESULT;
                    rsa_addr_q    <= '0;
                    state         <= WAIT;
                end
                // Only a fresh 0->1 transition of rsa_ready ends the wait
                WAIT: begin
                    if (rdy_rise_c) begin
                        rsa_oe_q      <= 1'b1;
                        rsa_reg_sel_q <= SEL_RESULT;
                        rsa_addr_q    <= idx;
                        state         <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    state <= RD_CAP;
                end
                // Read data returns one cycle after the request is presented
                RD_CAP: begin
                    rsa_oe_q    <= 1'b0;
                    out_data_q  <= bus.rsa_data_o;
                    out_valid_q <= 1'b1;
                    state       <= OUT_HOLD;
                end
                OUT_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx == IDX_LAST) begin
                            idx       <= '0;
                            blk_cnt_q <= blk_cnt_q + CNT_W'(1);
                            state     <= LOAD_C;
                        end else begin
                            idx           <= idx + IDX_W'(1);
                            rsa_oe_q      <= 1'b1;
                            rsa_reg_sel_q <= SEL_RESULT;
                            rsa_addr_q    <= idx + IDX_W'(1);
                            state         <= RD_REQ;
                        end
                    end
                end
                default: begin
                    state <= LOAD_A;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Drive the interface
    assign bus.in_ready    = in_ready_c;
    assign bus.busy        = !idle_c;
    assign bus.blk_cnt     = blk_cnt_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.rsa_we      = rsa_we_q;
    assign bus.rsa_oe      = rsa_oe_q;
    assign bus.rsa_start   = rsa_start_q;
    assign bus.rsa_reg_sel = rsa_reg_sel_q;
    assign bus.rsa_addr    = rsa_addr_q;
    assign bus.rsa_data_i  = rsa_data_i_q;
endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Scoreboard bench for rsa_host_ctrl: stimulus queues expected RSA writes and
// result bytes, a negedge monitor pops and compares them as the DUT emits.
module tb_rsa_host_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_out[$];

    rsa_host_ctrl_if bus ();

    rsa_host_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RSA core read model: result byte k is 0x80+k, one cycle after rsa_oe
    always @(posedge clk) begin
        if (bus.rsa_oe) bus.rsa_data_o <= 8'(8'h80 + {3'b000, bus.rsa_addr});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every RSA write and every result handshake against the queues
    always @(negedge clk) begin
        wr_t        e;
        logic [7:0] o;
        if (reset) begin
            if (bus.rsa_we) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsa_write: unexpected write sel=%0d addr=%0d data=0x%0h",
                             bus.rsa_reg_sel, bus.rsa_addr, bus.rsa_data_i);
                end else begin
                    e = exp_wr.pop_front();
                    check("rsa_write", 32'({bus.rsa_reg_sel, bus.rsa_addr, bus.rsa_data_i}), 32'(e));
                end
            end
            if (bus.rsa_we && bus.rsa_oe) check("we_oe_exclusive", 32'd1, 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_out.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_data: unexpected byte 0x%0h", bus.out_data);
                end else begin
                    o = exp_out.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(o));
                end
            end
        end
    end

    task automatic send_byte(input logic [1:0] sel, input logic [4:0] addr, input logic [7:0] b);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        exp_wr.push_back({sel, addr, b});
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) fail_now("in_ready");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic load_key(input logic [7:0] base);
        for (int i = 0; i < 64; i++) begin
            send_byte((i < 32) ? 2'd3 : 2'd2, 5'(i % 32), 8'(base + 8'(i)));
            check("busy_key", 32'(bus.busy), (i == 63) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic load_block(input logic [7:0] base);
        for (int k = 0; k < 32; k++) begin
            send_byte(2'd1, 5'(k), 8'(base + 8'(k)));
            check("busy_block", 32'(bus.busy), 32'd1);
        end
    endtask

    // GAP/START framing, then drive the ready edge and check the first read request
    task automatic start_and_ready(input bit pre_high);
        int seen;
        @(negedge clk);
        check("start_during_last_write", 32'(bus.rsa_start), 32'd0);
        @(negedge clk);
        check("gap_quiet", 32'({bus.rsa_we, bus.rsa_start}), 32'd0);
        @(negedge clk);
        check("start_pulse", 32'({bus.rsa_start, bus.rsa_reg_sel, bus.rsa_addr}), 32'b1_00_00000);
        @(negedge clk);
        check("start_single", 32'(bus.rsa_start), 32'd0);
        if (pre_high) begin
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.rsa_oe) seen++;
            end
            check("no_read_on_high_level", 32'(seen), 32'd0);
            @(posedge clk);
            #1 bus.rsa_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus.rsa_ready = 1'b1;
        end else begin
            repeat (49) @(posedge clk);
            #1 bus.rsa_ready = 1'b1;
        end
        @(negedge clk);
        check("no_read_on_edge_cycle", 32'(bus.rsa_oe), 32'd0);
        @(negedge clk);
        check("rd_req_after_edge", 32'({bus.rsa_oe, bus.rsa_reg_sel, bus.rsa_addr}), 32'b1_00_00000);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("out_valid");
    endtask

    // Read back nbytes result bytes; bp_byte (if <32) is held off for 10 cycles
    task automatic read_block(input int nbytes, input int bp_byte);
        bit ok;
        int unsigned last_cyc;
        for (int k = 0; k < 32; k++) exp_out.push_back(8'(8'h80 + 8'(k)));
        bus.out_ready = (bp_byte == 0) ? 1'b0 : 1'b1;
        last_cyc = 0;
        for (int k = 0; k < nbytes; k++) begin
            wait_valid(ok);
            if (!ok) return;
            if (k == bp_byte) begin
                for (int i = 0; i < 10; i++) begin
                    check("backpressure_hold", 32'({bus.out_valid, bus.out_data, bus.rsa_oe}),
                          32'({1'b1, 8'(8'h80 + 8'(k)), 1'b0}));
                    if (i < 9) @(negedge clk);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
                @(negedge clk);
            end else if (k > 0 && k != bp_byte + 1) begin
                check("byte_cadence", cyc - last_cyc, 32'd3);
            end
            last_cyc = cyc;
            @(posedge clk);
            #1;
            if (k + 1 == bp_byte) bus.out_ready = 1'b0;
        end
    endtask

    task automatic end_of_block(input logic [7:0] exp_cnt);
        check("blk_cnt", 32'(bus.blk_cnt), 32'(exp_cnt));
        check("idle_ready", 32'({bus.in_ready, bus.busy}), 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.out_ready  = 1'b1;
        bus.rekey      = 1'b0;
        bus.rsa_ready  = 1'b0;
        bus.rsa_data_o = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({bus.rsa_we, bus.rsa_oe, bus.rsa_start, bus.rsa_reg_sel,
              bus.rsa_addr, bus.rsa_data_i, bus.out_valid, bus.out_data}), 32'd0);
        check("reset_ready_busy", 32'({bus.in_ready, bus.busy}), 32'b11);
        check("reset_blk_cnt", 32'(bus.blk_cnt), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Key load and first block with an in-order readback
        load_key(8'h00);
        load_block(8'hA0);
        start_and_ready(1'b0);
        read_block(32, 99);
        end_of_block(8'd1);
        bus.rsa_ready = 1'b0;

        // Second block with backpressure on byte 5; ready left high afterwards
        load_block(8'h10);
        start_and_ready(1'b0);
        read_block(32, 5);
        end_of_block(8'd2);

        // Third block: ready already high on entry to WAIT
        load_block(8'h60);
        start_and_ready(1'b1);
        read_block(32, 99);
        end_of_block(8'd3);
        bus.rsa_ready = 1'b0;

        // Rekey with a simultaneous byte: byte dropped, key reload starts at reg 3 addr 0
        bus.rekey    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        @(negedge clk);
        check("rekey_blocks_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.rekey    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rekey_no_write_busy", 32'({bus.rsa_we, bus.busy}), 32'b01);
        @(posedge clk);
        #1;
        load_key(8'h40);

        // Fourth block aborted by reset during result byte 12
        load_block(8'hC0);
        start_and_ready(1'b0);
        read_block(12, 99);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.rsa_oe) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("byte12_read");
        #2 reset = 1'b0;
        #1;
        check("abort_outputs", 32'({bus.rsa_we, bus.rsa_oe, bus.rsa_start, bus.rsa_reg_sel,
              bus.rsa_addr, bus.rsa_data_i, bus.out_valid, bus.out_data}), 32'd0);
        check("abort_ready_busy", 32'({bus.in_ready, bus.busy}), 32'b11);
        check("abort_blk_cnt", 32'(bus.blk_cnt), 32'd0);
        exp_out.delete();
        bus.rsa_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Key must be reloaded after the abort
        load_key(8'h20);
        check("post_reset_blk_cnt", 32'(bus.blk_cnt), 32'd0);
        repeat (3) @(posedge clk);
        check("queues_drained", 32'(exp_wr.size() + exp_out.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rsa_host_ctrl.md
RSA_HOST_CTRL -- requirements
Module: rsa_host_ctrl

Interface
REQ-001 The block SHALL be a host-side master for the byte-wide RSA register port: it loads key and ciphertext, pulses start, waits for ready, and reads back the result.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream byte available.
REQ-005 in_data  input  8  upstream byte.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 out_valid  output  1  out_data holds a result byte.
REQ-008 out_data  output  8  result byte.
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 rekey  input  1  request to reload the key words.
REQ-011 rsa_we, rsa_oe, rsa_start  output  1 each  RSA port write enable, read enable, start pulse.
REQ-012 rsa_reg_sel  output  2  RSA register select: 3 = key word A, 2 = key word B, 1 = ciphertext, 0 = result.
REQ-013 rsa_addr  output  5  byte index within the 256-bit register; byte k = bits [8k+7:8k].
REQ-014 rsa_data_i  output  8  write data to RSA.
REQ-015 rsa_data_o  input  8  RSA read data, valid one cycle after rsa_oe/rsa_addr are presented.
REQ-016 rsa_ready  input  1  RSA completion flag.
REQ-017 busy  output  1  high in every state except LOAD_C with byte index 0.
REQ-018 blk_cnt  output  8  completed blocks since reset; wraps 255 -> 0.

Function
REQ-019 All RSA-side outputs and out_data/out_valid SHALL be registered.
REQ-020 States: LOAD_A, LOAD_B, LOAD_C, GAP, START, WAIT, RD_REQ, RD_CAP, OUT_HOLD.
REQ-021 in_ready SHALL be 1 only in LOAD_A, LOAD_B and LOAD_C, and 0 whenever rekey=1.
REQ-022 Each accepted byte (in_valid & in_ready) at index k SHALL produce, on the next cycle, rsa_we=1, rsa_reg_sel per state, rsa_addr=k and rsa_data_i=byte; rsa_we SHALL be 0 in cycles with no accepted byte.
REQ-023 The byte index SHALL increment per accepted byte, 0..31; after byte 31 LOAD_A->LOAD_B, LOAD_B->LOAD_C, LOAD_C->GAP, with the index cleared to 0.
REQ-024 GAP SHALL last one cycle with rsa_we=0; START SHALL drive rsa_start=1 for exactly one cycle with rsa_reg_sel=0 and rsa_addr=0.
REQ-025 WAIT SHALL exit only on a rising edge of rsa_ready (current 1, previous-cycle sample 0); a level already high on entry SHALL NOT count.
REQ-026 RD_REQ SHALL drive rsa_oe=1, rsa_reg_sel=0 and rsa_addr=k for one cycle. RD_CAP SHALL keep rsa_oe=1, load out_data with rsa_data_o and set out_valid=1.
REQ-027 OUT_HOLD SHALL hold out_data and out_valid stable until out_ready=1. On that handshake out_valid clears; then, if k<31, go to RD_REQ with k+1; if k=31, increment blk_cnt and go to LOAD_C with index 0.
REQ-028 Result bytes SHALL leave in address order 0..31; there is at most one byte in flight.
REQ-029 rekey SHALL be honoured only in LOAD_C at index 0: next state LOAD_A, index 0. Elsewhere it SHALL be ignored. rekey with a simultaneous in_valid SHALL win, and the byte SHALL NOT be accepted.
REQ-030 rsa_oe and rsa_we SHALL never be high in the same cycle.

Reset
REQ-031 While reset=0, the block SHALL be in LOAD_A with index 0; all outputs SHALL be 0 except in_ready=1 and busy=1; blk_cnt=0; the rsa_ready edge register SHALL be cleared to 0.
REQ-032 Reset asserted mid-operation SHALL abort immediately. The key SHALL be reloaded: the first 64 bytes after release go to reg_sel 3 then 2.

Verification
REQ-033 Key load: 64 back-to-back bytes 0x00..0x3F -> 32 writes to reg_sel 3 with addr 0..31 and data 0x00..0x1F, then 32 writes to reg_sel 2 with data 0x20..0x3F; busy=1 throughout, and busy=0 after the last byte.
REQ-034 Block: 32 ciphertext bytes 0xA0.. -> reg_sel 1 writes, one GAP cycle, a single-cycle rsa_start; the model raises rsa_ready 50 cycles later -> RD_REQ starts on the cycle after the edge.
REQ-035 Readback with model result byte k = 0x80+k and out_ready held 1 -> out_data sequence 0x80..0x9F, one byte per 3 cycles; blk_cnt becomes 1 and in_ready returns to 1.
REQ-036 Backpressure: out_ready=0 for 10 cycles on byte 5 -> out_data=0x85 stable and out_valid=1 for all 10 cycles, with no rsa_oe pulses.
REQ-037 rsa_ready already high when WAIT is entered -> no read until rsa_ready falls and rises again; rekey with in_valid=1 at index 0 -> no byte accepted, next write goes to reg_sel 3 addr 0.
REQ-038 reset=0 during byte 12 of readback -> all outputs reset within the same cycle; blk_cnt=0 and state LOAD_A after release.
